// File: rtl/midi_voice_alloc.sv
// MIDI note-on/note-off parser with running status driving a fixed oscillator voice pool with round-robin stealing.
// Optional sustain pedal (CC64) handling is compiled in when MIDI_SUSTAIN_EN is defined.
module midi_voice_alloc #(
  parameter int  NUM_VOICES   = 4,
  parameter int  MIDI_CHANNEL = 0,
  localparam int SW           = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic [7:0]              midiData_i,
  input  logic                    dataReady_i,
  output logic [7*NUM_VOICES-1:0] voiceNote_o,
  output logic [NUM_VOICES-1:0]   voiceGate_o,
  output logic                    voiceUpdate_o,
  output logic [SW-1:0]           stealPtr_o
);

  typedef enum logic [1:0] {IDLE, WAIT_KEY, WAIT_VEL} state_t;
  typedef enum logic [1:0] {RS_NONE, RS_OFF, RS_ON, RS_CC} rs_t;

  state_t                state_reg;
  rs_t                   rs_reg;
  logic [6:0]            key_reg;
  logic [6:0]            note_reg [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_reg;
  logic                  update_reg;
  logic [SW-1:0]         steal_reg;
`ifdef MIDI_SUSTAIN_EN
  logic [NUM_VOICES-1:0] held_reg;
  logic                  sustain_reg;
`endif

  logic [NUM_VOICES-1:0] match_vec;
  logic                  any_match;
  logic                  any_free;
  logic [SW-1:0]         free_idx;
  rs_t                   status_kind;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign match_vec[gi]          = gate_reg[gi] && (note_reg[gi] == key_reg);
      assign voiceNote_o[7*gi +: 7] = note_reg[gi];
    end
  endgenerate

  assign any_match     = |match_vec;
  assign any_free      = ~&gate_reg;
  assign voiceGate_o   = gate_reg;
  assign voiceUpdate_o = update_reg;
  assign stealPtr_o    = steal_reg;

  // Lowest-index free voice: scan downward so the last hit is the lowest index.
  always_comb begin
    free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!gate_reg[v]) free_idx = SW'(v);
    end
  end

  always_comb begin
    status_kind = RS_NONE;
    if (midiData_i[3:0] == 4'(MIDI_CHANNEL)) begin
      case (midiData_i[7:4])
        4'h8:    status_kind = RS_OFF;
        4'h9:    status_kind = RS_ON;
`ifdef MIDI_SUSTAIN_EN
        4'hB:    status_kind = RS_CC;
`endif
        default: status_kind = RS_NONE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_reg  <= IDLE;
      rs_reg     <= RS_NONE;
      key_reg    <= '0;
      gate_reg   <= '0;
      update_reg <= 1'b0;
      steal_reg  <= '0;
      for (int v = 0; v < NUM_VOICES; v++) note_reg[v] <= '0;
`ifdef MIDI_SUSTAIN_EN
      held_reg    <= '0;
      sustain_reg <= 1'b0;
`endif
    end else begin
      update_reg <= 1'b0;
      // Realtime bytes (0xF8..0xFF) fall outside this guard and leave every register untouched.
      if (dataReady_i && (midiData_i < 8'hF8)) begin
        if (midiData_i[7]) begin
          rs_reg    <= status_kind;
          state_reg <= (status_kind == RS_NONE) ? IDLE : WAIT_KEY;
        end else if (state_reg == WAIT_KEY) begin
          key_reg   <= midiData_i[6:0];
          state_reg <= WAIT_VEL;
        end else if (state_reg == WAIT_VEL) begin
          state_reg <= WAIT_KEY;
          if (rs_reg == RS_ON && midiData_i[6:0] != 7'd0) begin
            update_reg <= 1'b1;
            if (any_match) begin
`ifdef MIDI_SUSTAIN_EN
              held_reg <= held_reg & ~match_vec;
`endif
            end else if (any_free) begin
              note_reg[free_idx] <= key_reg;
              gate_reg[free_idx] <= 1'b1;
            end else begin
              note_reg[steal_reg] <= key_reg;
`ifdef MIDI_SUSTAIN_EN
              held_reg[steal_reg] <= 1'b0;
`endif
              steal_reg <= (steal_reg == SW'(NUM_VOICES - 1)) ? '0 : steal_reg + 1'b1;
            end
          end else if (rs_reg == RS_ON || rs_reg == RS_OFF) begin
`ifdef MIDI_SUSTAIN_EN
            if (sustain_reg) begin
              held_reg <= held_reg | match_vec;
            end else begin
              gate_reg   <= gate_reg & ~match_vec;
              update_reg <= any_match;
            end
`else
            gate_reg   <= gate_reg & ~match_vec;
            update_reg <= any_match;
`endif
          end
`ifdef MIDI_SUSTAIN_EN
          else if (rs_reg == RS_CC && key_reg == 7'd64) begin
            if (midiData_i[6]) begin
              sustain_reg <= 1'b1;
            end else begin
              sustain_reg <= 1'b0;
              gate_reg    <= gate_reg & ~held_reg;
              held_reg    <= '0;
              update_reg  <= |held_reg;
            end
          end
`endif
        end
      end
    end
  end

endmodule

// File: doc/midi_voice_alloc.md
# midi_voice_alloc

- Parses the MIDI byte stream from the UART receiver: note-on, note-off and running status.
- Assigns notes to a fixed pool of oscillator voices, which is the synth's shared resource.
- Drives one note number and one gate per voice to the oscillator bank, plus a one-cycle update strobe.
- Sits between `rx` (byte + `dataReady`) and the oscillator/PWM stage inside the synth top level.

## Interface

- `NUM_VOICES`, default 4: number of oscillator voices, 1..8.
- `MIDI_CHANNEL`, default 0: accepted channel nibble, 0..15.
- `clk_i` in 1: system clock.
- `nrst_i` in 1: reset, asynchronous, active-low.
- `midiData_i` in 8: received MIDI byte, valid when `dataReady_i`=1.
- `dataReady_i` in 1: one-cycle strobe, one byte per strobe; may be asserted on consecutive cycles.
- `voiceNote_o` out 7*NUM_VOICES: voice v note at bits [7v+6:7v].
- `voiceGate_o` out NUM_VOICES: 1 = voice v sounding.
- `voiceUpdate_o` out 1: one-cycle pulse when any note/gate register changed.
- `stealPtr_o` out $clog2(NUM_VOICES) (min 1): next voice to steal, for debug.

## Operation

- Parser FSM, one byte per `dataReady_i`:
  - `IDLE`: no running status.
  - `WAIT_KEY`: running status held.
  - `WAIT_VEL`: key byte latched.
- Status byte 0x80|ch or 0x90|ch with ch==MIDI_CHANNEL: store as running status, go to `WAIT_KEY`.
- Byte 0xF8..0xFF (realtime): ignored completely; state, running status and latched key are unchanged.
- Any other status byte (0x80..0xF7): clear running status, go to `IDLE`.
- Data byte (bit7=0):
  - In `IDLE`: discarded.
  - In `WAIT_KEY`: latch key, go to `WAIT_VEL`.
  - In `WAIT_VEL`: execute the message and return to `WAIT_KEY`; running status is kept.
- Note-on = status 0x9n with vel≠0. Note-off = status 0x8n, or 0x9n with vel=0.
- Note-on allocation, first match wins:
  1. A voice with gate=1 and note==key: retrigger it. Gate stays 1; no register changes, but the update pulse still fires.
  2. The lowest-index voice with gate=0: load key, set gate.
  3. Otherwise steal voice `stealPtr`: load key, gate stays 1, `stealPtr` increments modulo NUM_VOICES.
- Note-off: clear the gate of every voice with gate=1 and note==key; note value is retained. If no voice matches, nothing changes and no update pulse fires.
- `stealPtr` changes only on a steal.
- Velocity value is otherwise unused.

## Timing

- Velocity byte strobe at cycle t: note/gate registers and `voiceUpdate_o` change at t+1. Latency is one clock.
- Voice match and free-voice search are combinational within cycle t.
- Back-to-back strobes are supported. A message completing at t and a status byte at t+1 are both processed.
- Reset values: `voiceNote_o`=0, `voiceGate_o`=0, `voiceUpdate_o`=0, `stealPtr_o`=0, FSM=`IDLE`, running status cleared, sustain state cleared.
- Reset asserted mid-message: the partial message is discarded. After release, data bytes are ignored until a valid status byte arrives.
- `dataReady_i`=0: all state holds.

## Configuration

- `MIDI_SUSTAIN_EN` defined:
  - 0xB0|ch (ch==MIDI_CHANNEL) becomes an accepted running status.
  - Completed CC with controller 64: value ≥64 sets `sustain`, value <64 clears it. Other controllers are ignored.
  - Note-off while `sustain`=1: the matching voice's `held` bit is set and its gate stays 1.
  - On `sustain` 1→0: every voice with `held`=1 has its gate and `held` cleared in the same cycle, and `voiceUpdate_o` pulses.
  - Note-on retrigger or steal of a voice clears its `held`.
  - A free voice is gate=0 only; held voices are not free.
- `MIDI_SUSTAIN_EN` undefined: 0xBn is treated as unsupported status (running status cleared). No `held`/`sustain` logic is synthesised.

## Test plan

1. Bytes 0x90,0x3C,0x64 → one cycle after the third strobe: voice0 note=0x3C, gate0=1, `voiceUpdate_o` high exactly one cycle.
2. Running status: 0x90,0x3C,0x64,0x40,0x64 → voice0=0x3C and voice1=0x40, both gated; `stealPtr_o`=0.
3. After case 1:
   - 0x80,0x3C,0x00 → gate0=0, note0 remains 0x3C.
   - Repeat the note-on, then 0x90,0x3C,0x00 → gate0=0.
   - 0x80,0x50,0x00 → no change, no update pulse.
4. NUM_VOICES=4, note-ons for keys 60,62,64,65,67 → keys 60..65 in voices 0..3, then key 67 overwrites voice0 and `stealPtr_o`=1. Note-on 62 again → no steal; voice1 retriggered, `stealPtr_o` stays 1.
5. Edge cases:
   - 0x90,0x3C,0xF8,0x64 → voice0=0x3C gated; the realtime byte has no effect.
   - 0x91,0x3C,0x64 with MIDI_CHANNEL=0 → no change.
   - Reset asserted between 0x3C and 0x64, then 0x64 → no change; all outputs at reset values.
6. `MIDI_SUSTAIN_EN`: 0xB0,0x40,0x7F, then 0x90,0x3C,0x64, then 0x80,0x3C,0x00 → gate0 stays 1. Then 0xB0,0x40,0x00 → gate0=0 one cycle later with an update pulse.
